// File: rtl/uart_rx_bus_interface.sv
// UART receiver DBus slave: samples an asynchronous RX pin, deframes 8N1
// characters into a FIFO, and exposes data/status/divisor/control registers.
module uart_rx_bus_interface #(
  parameter int unsigned ADDR_SEL_BITS   = 13,
  parameter int unsigned CLKS_PER_BIT    = 651,
  parameter int unsigned FIFO_DEPTH_BITS = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_SlaveSel,
  input  logic [29-ADDR_SEL_BITS:0] i_RegAddr,
  input  logic [3:0]               i_AV_ByteEn,
  input  logic                     i_AV_Read,
  input  logic                     i_AV_Write,
  output logic [31:0]              o_AV_ReadData,
  input  logic [31:0]              i_AV_WriteData,
  output logic                     o_AV_WaitRequest,
  input  logic                     i_UART_RX
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] DepthCount = (FIFO_DEPTH_BITS+1)'(Depth);
  localparam logic [15:0] DivReset = 16'(CLKS_PER_BIT);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} rxState_t;

  logic       rxMeta, rxSync, rxPrev;
  logic [1:0] syncFill;
  logic       rxArmed;
  logic       fallEdge;

  rxState_t   rxState;
  logic [15:0] bitCnt, divLatched;
  logic       cntDone;
  logic [2:0] bitIdx;
  logic [7:0] shiftReg;
  logic       rxValid;
  logic [7:0] rxByte;
  logic       frameErrSet;

  logic [15:0] divisor, divNext;
  logic [7:0]  fifoMem [Depth];
  logic [FIFO_DEPTH_BITS-1:0] wrPtr, rdPtr;
  logic [FIFO_DEPTH_BITS:0]   fifoCount;
  logic fifoEmpty, fifoFull;
  logic overrun, frameErr;

  logic       readEn, writeEn;
  logic [1:0] regIdx;
  logic       popReq, pushAccept, overrunSet, overrunClr, frameErrClr;
  logic [31:0] statusWord;
  logic [7:0]  headByte;
  logic        unusedBits;

  assign readEn      = i_SlaveSel & i_AV_Read;
  assign writeEn     = i_SlaveSel & i_AV_Write;
  assign regIdx      = i_RegAddr[1:0];
  assign fifoEmpty   = (fifoCount == '0);
  assign fifoFull    = (fifoCount == DepthCount);
  assign popReq      = readEn && (regIdx == 2'd0) && !fifoEmpty;
  assign pushAccept  = rxValid && (!fifoFull || popReq);
  assign overrunSet  = rxValid && fifoFull && !popReq;
  assign overrunClr  = writeEn && (regIdx == 2'd3) && i_AV_ByteEn[0] && i_AV_WriteData[0];
  assign frameErrClr = writeEn && (regIdx == 2'd3) && i_AV_ByteEn[0] && i_AV_WriteData[1];
  assign fallEdge    = rxArmed && rxPrev && !rxSync;
  assign cntDone     = (bitCnt <= 16'd1);
  assign o_AV_WaitRequest = 1'b0;
  assign unusedBits  = &{1'b0, i_RegAddr[29-ADDR_SEL_BITS:2], i_AV_ByteEn[3:2], i_AV_WriteData[31:16]};

  // Two-flop synchronizer plus previous-value flop for falling-edge detection.
  // Edge detection stays disarmed after reset until the refilled pipeline has
  // shown the real line high, so a line held low through reset is not a start.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rxMeta   <= 1'b1;
      rxSync   <= 1'b1;
      rxPrev   <= 1'b1;
      syncFill <= '0;
      rxArmed  <= 1'b0;
    end else begin
      rxMeta <= i_UART_RX;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      if (syncFill != 2'd2) syncFill <= syncFill + 2'd1;
      if (syncFill == 2'd2 && rxSync) rxArmed <= 1'b1;
    end
  end

  // Receive FSM: start detection, mid-bit sampling, stop check, break wait.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rxState     <= StIdle;
      bitCnt      <= '0;
      divLatched  <= DivReset;
      bitIdx      <= '0;
      shiftReg    <= '0;
      rxValid     <= 1'b0;
      rxByte      <= '0;
      frameErrSet <= 1'b0;
    end else begin
      rxValid     <= 1'b0;
      frameErrSet <= 1'b0;
      case (rxState)
        StIdle: begin
          if (fallEdge) begin
            divLatched <= divisor;
            bitCnt     <= divisor >> 1;
            rxState    <= StStart;
          end
        end
        StStart: begin
          if (cntDone) begin
            if (!rxSync) begin
              bitCnt  <= divLatched;
              bitIdx  <= '0;
              rxState <= StData;
            end else begin
              rxState <= StIdle;
            end
          end else begin
            bitCnt <= bitCnt - 16'd1;
          end
        end
        StData: begin
          if (cntDone) begin
            shiftReg[bitIdx] <= rxSync;
            bitCnt <= divLatched;
            if (bitIdx == 3'd7) rxState <= StStop;
            else                bitIdx  <= bitIdx + 3'd1;
          end else begin
            bitCnt <= bitCnt - 16'd1;
          end
        end
        StStop: begin
          if (cntDone) begin
            if (rxSync) begin
              rxValid <= 1'b1;
              rxByte  <= shiftReg;
              rxState <= StIdle;
            end else begin
              frameErrSet <= 1'b1;
              rxState     <= StBreak;
            end
          end else begin
            bitCnt <= bitCnt - 16'd1;
          end
        end
        StBreak: begin
          if (rxSync) rxState <= StIdle;
        end
        default: rxState <= StIdle;
      endcase
    end
  end

  // Byte-enabled divisor update with a floor of 4 clocks per bit.
  always_comb begin
    divNext[15:8] = i_AV_ByteEn[1] ? i_AV_WriteData[15:8] : divisor[15:8];
    divNext[7:0]  = i_AV_ByteEn[0] ? i_AV_WriteData[7:0]  : divisor[7:0];
    if (divNext < 16'd4) divNext = 16'd4;
  end

  // Divisor register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)                                 divisor <= DivReset;
    else if (writeEn && regIdx == 2'd2)        divisor <= divNext;
  end

  // FIFO pointers and occupancy; a pop frees space for a same-cycle push.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (pushAccept) wrPtr <= wrPtr + 1'b1;
      if (popReq)     rdPtr <= rdPtr + 1'b1;
      case ({pushAccept, popReq})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset.
  always_ff @(posedge i_Clk) begin
    if (pushAccept) fifoMem[wrPtr] <= rxByte;
  end

  // Sticky error flags; a set wins over a same-cycle clear.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      overrun  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      overrun  <= overrunSet  | (overrun  & ~overrunClr);
      frameErr <= frameErrSet | (frameErr & ~frameErrClr);
    end
  end

  // Combinational read mux, forced to zero unless this slave is being read.
  always_comb begin
    headByte = fifoEmpty ? 8'h00 : fifoMem[rdPtr];
    statusWord = '0;
    statusWord[0] = !fifoEmpty;
    statusWord[1] = fifoFull;
    statusWord[2] = overrun;
    statusWord[3] = frameErr;
    statusWord[8 +: FIFO_DEPTH_BITS+1] = fifoCount;
    o_AV_ReadData = '0;
    if (readEn) begin
      case (regIdx)
        2'd0:    o_AV_ReadData = {24'b0, headByte};
        2'd1:    o_AV_ReadData = statusWord;
        2'd2:    o_AV_ReadData = {16'b0, divisor};
        default: o_AV_ReadData = '0;
      endcase
    end
  end

endmodule
